// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared defaults and saturation helper for the plant-side PID blocks
package pid_pkg;

  localparam int unsigned DEF_BITS   = 8;
  localparam int unsigned DEF_WINDOW = 256;

  // All-ones value of a BITS-wide unsigned word (the saturation ceiling).
  function automatic logic [31:0] sat_max(input int unsigned bits);
    return (32'h1 << bits) - 32'h1;
  endfunction

endpackage

// File: rtl/pid_plant_io_tach_sync.sv
// rtl/pid_plant_io_tach_sync.sv - tach synchronizer with rising-edge pulse
module tach_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic tach_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= tach_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~hist_q;

endmodule

// File: rtl/pid_plant_io.sv
// rtl/pid_plant_io.sv - PWM actuator drive and windowed tach measurement feeding pv back to the PID core
module pid_plant_io
  import pid_pkg::*;
#(
  parameter  int BITS   = DEF_BITS,
  parameter  int WINDOW = DEF_WINDOW,
  localparam int CW     = $clog2(WINDOW)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [BITS-1:0] stimulus,
  input  logic            tach_in,
  output logic            pwm_out,
  output logic [BITS-1:0] pv,
  output logic            pv_stb,
  output logic            pv_sat
);

  localparam logic [BITS-1:0] MAX    = BITS'(sat_max(BITS));
  localparam logic [CW-1:0]   W_LAST = CW'(WINDOW - 1);

  logic            tach_edge;
  logic [BITS-1:0] pcnt_q, pcnt_d;
  logic [BITS-1:0] duty_q, duty_d;
  logic            pwm_q, pwm_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [BITS-1:0] ecnt_q, ecnt_d;
  logic            ovf_q, ovf_d;
  logic [BITS-1:0] pv_q, pv_d;
  logic            pv_stb_q, pv_stb_d;
  logic            pv_sat_q, pv_sat_d;

  tach_sync u_tach_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .tach_i  (tach_in),
    .edge_o  (tach_edge)
  );

  always_comb begin
    pcnt_d   = pcnt_q;
    duty_d   = duty_q;
    wcnt_d   = wcnt_q;
    ecnt_d   = ecnt_q;
    ovf_d    = ovf_q;
    pv_d     = pv_q;
    pv_sat_d = pv_sat_q;
    pv_stb_d = 1'b0;
    pwm_d    = en && (pcnt_q < duty_q);

    if (en) begin
      pcnt_d = pcnt_q + BITS'(1);
      // Duty only changes at the period boundary so a period is never cut short.
      if (pcnt_q == MAX) begin
        duty_d = stimulus;
      end

      if (wcnt_q == W_LAST) begin
        // An edge on the terminal cycle still belongs to the closing window.
        wcnt_d   = '0;
        pv_stb_d = 1'b1;
        pv_d     = (tach_edge && ecnt_q != MAX) ? ecnt_q + BITS'(1) : ecnt_q;
        pv_sat_d = ovf_q | ((ecnt_q == MAX) && tach_edge);
        ecnt_d   = '0;
        ovf_d    = 1'b0;
      end else begin
        wcnt_d = wcnt_q + CW'(1);
        if (tach_edge) begin
          if (ecnt_q == MAX) begin
            ovf_d = 1'b1;
          end else begin
            ecnt_d = ecnt_q + BITS'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q   <= '0;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
      wcnt_q   <= '0;
      ecnt_q   <= '0;
      ovf_q    <= 1'b0;
      pv_q     <= '0;
      pv_stb_q <= 1'b0;
      pv_sat_q <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      wcnt_q   <= wcnt_d;
      ecnt_q   <= ecnt_d;
      ovf_q    <= ovf_d;
      pv_q     <= pv_d;
      pv_stb_q <= pv_stb_d;
      pv_sat_q <= pv_sat_d;
    end
  end

  assign pwm_out = pwm_q;
  assign pv      = pv_q;
  assign pv_stb  = pv_stb_q;
  assign pv_sat  = pv_sat_q;

endmodule

// File: tb/tb_pid_plant_io.sv
// tb/tb_pid_plant_io.sv - randomized self-checking bench for pid_plant_io against a behavioural model
module tb_pid_plant_io;

  localparam int BITS   = 8;
  localparam int WINDOW = 1024;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            en = 1'b0;
  logic [BITS-1:0] stimulus = '0;
  logic            tach_in = 1'b0;
  logic            pwm_out;
  logic [BITS-1:0] pv;
  logic            pv_stb;
  logic            pv_sat;

  int errors = 0;
  int checks = 0;
  int tper = 0;

  // Behavioural model state
  int mp = 0, mduty = 0, macc = 0, mw = 0;
  bit h1 = 0, h2 = 0, h3 = 0;
  bit m_pwm = 0, m_stb = 0, m_sat = 0;
  int m_pv = 0;

  pid_plant_io #(.BITS(BITS), .WINDOW(WINDOW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .stimulus (stimulus),
    .tach_in  (tach_in),
    .pwm_out  (pwm_out),
    .pv       (pv),
    .pv_stb   (pv_stb),
    .pv_sat   (pv_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edge counted at clock n iff tach sampled high two clocks earlier and low three earlier;
  // pwm high while phase-in-period < duty; pv is the plain edge total of each WINDOW enabled clocks, clipped.
  initial begin
    bit e;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mp = 0; mduty = 0; macc = 0; mw = 0;
        h1 = 0; h2 = 0; h3 = 0;
        m_pwm = 0; m_stb = 0; m_pv = 0; m_sat = 0;
      end else begin
        e = h2 && !h3;
        h3 = h2; h2 = h1; h1 = tach_in;
        m_pwm = en && (mp < mduty);
        m_stb = 0;
        if (en) begin
          if (mp == 255) mduty = int'(stimulus);
          mp = (mp + 1) % 256;
          macc += int'(e);
          mw++;
          if (mw == WINDOW) begin
            m_stb = 1;
            m_pv  = (macc > 255) ? 255 : macc;
            m_sat = (macc > 255);
            macc  = 0;
            mw    = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
      chk("pv_stb",  32'(pv_stb),  32'(m_stb));
      chk("pv",      32'(pv),      32'(m_pv));
      chk("pv_sat",  32'(pv_sat),  32'(m_sat));
    end
  end

  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #2;
      if (tper == 0) begin
        tach_in = 1'($urandom % 2);
      end else begin
        tc = (tc + 1) % tper;
        tach_in = (tc < tper / 2);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_stb(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pv_stb !== 1'b1 && n < maxc);
    if (pv_stb !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_stb: no pv_stb within %0d cycles", maxc);
    end
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
    end
  endtask

  task automatic async_reset_check();
    reset_n = 1'b0;
    #1;
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_pv",  32'(pv),      0);
    chk("rst_stb", 32'(pv_stb),  0);
    chk("rst_sat", 32'(pv_sat),  0);
  endtask

  initial begin
    int n, hi;
    step(3);
    chk("reset_pwm", 32'(pwm_out), 0);
    chk("reset_pv",  32'(pv),      0);
    chk("reset_stb", 32'(pv_stb),  0);
    chk("reset_sat", 32'(pv_sat),  0);

    // Measurement and 25% duty
    reset_n = 1'b1; en = 1'b1; stimulus = 8'd64; tper = 8;
    step(600);
    count_pwm(256, hi);
    chk("duty64_highs", 32'(hi), 64);
    wait_stb(3000, n);
    wait_stb(1100, n);
    chk("stb_interval", 32'(n), WINDOW);
    chk("pv_tach8", 32'(pv), 128);
    chk("sat_tach8", 32'(pv_sat), 0);

    // Saturation, then recovery
    step(1); tper = 2;
    wait_stb(1100, n); wait_stb(1100, n);
    chk("pv_tach2", 32'(pv), 255);
    chk("sat_tach2", 32'(pv_sat), 1);
    step(1); tper = 16;
    wait_stb(1100, n); wait_stb(1100, n);
    chk("pv_tach16", 32'(pv), 64);
    chk("sat_tach16", 32'(pv_sat), 0);

    // Exactly 256 edges per window overflows by one
    step(1); tper = 4;
    wait_stb(1100, n); wait_stb(1100, n);
    chk("pv_tach4", 32'(pv), 255);
    chk("sat_tach4", 32'(pv_sat), 1);

    // Zero duty and a disabled stretch mid-window
    step(1); stimulus = 8'd0;
    step(300);
    count_pwm(256, hi);
    chk("duty0_highs", 32'(hi), 0);
    stimulus = 8'd200;
    step(400);
    en = 1'b0;
    step(1);
    count_pwm(99, hi);
    chk("disabled_highs", 32'(hi), 0);
    step(1); en = 1'b1;
    step(200);

    // Reset in the middle of a window
    async_reset_check();
    step(2);
    reset_n = 1'b1;
    step(50);

    // Randomized traffic
    for (int i = 0; i < 9000; i++) begin
      step(1);
      if (en) en = ($urandom % 200) != 0;
      else    en = ($urandom % 20) == 0;
      if ($urandom % 100 == 0) stimulus = 8'($urandom);
      if (i % 1100 == 0) tper = $urandom_range(0, 7);
      if (tper == 1) tper = 3;
      if (i == 4500) async_reset_check();
      if (i == 4502) reset_n = 1'b1;
    end
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
